// File: rtl/anita3_trig_pattern_buffer_pkg.sv
// Shared ANITA3 trigger constants: record field widths and counter sizes.
package anita3_trig_pattern_buffer_pkg;

    localparam int TS_W     = 16;
    localparam int DROP_W   = 8;
    localparam int CNT_W    = 8;
    localparam int FILL_W   = 5;
    localparam int REC_XW   = CNT_W + TS_W;

    // Record is {phi[2*num_phi], count[8], timestamp[16]}
    function automatic int rec_width(input int num_phi);
        return 2 * num_phi + REC_XW;
    endfunction

endpackage

// File: rtl/anita3_trig_record_fifo.sv
// Trigger record storage with wrap-bit pointers; head is read combinationally.
module anita3_trig_record_fifo
    import anita3_trig_pattern_buffer_pkg::*;
#(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_valid,
    output logic              o_full,
    output logic [FILL_W-1:0] o_fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    w_diff;
    logic             w_wr;
    logic             w_rd;

    assign w_diff    = r_wr - r_rd;
    assign o_fill    = FILL_W'(w_diff);
    assign o_valid   = (r_wr != r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) &&
                       (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_rd_data = r_mem[r_rd[AW-1:0]];

    // Full is judged before this cycle's read, so a read never frees a slot early
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && o_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr[AW-1:0]] <= i_wr_data;
                r_wr <= r_wr + 1'b1;
            end
            if (w_rd) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/anita3_trig_pattern_buffer.sv
// Buffers phi-pattern trigger records with timestamps; tracks dropped triggers.
module anita3_trig_pattern_buffer
    import anita3_trig_pattern_buffer_pkg::*;
#(
    parameter int NUM_PHI = 16,
    parameter int DEPTH   = 4
) (
    input  logic                 clk250_i,
    input  logic                 rst_n_i,
    input  logic                 trig_i,
    input  logic [2*NUM_PHI-1:0] phi_i,
    input  logic [CNT_W-1:0]     count_i,
    input  logic                 rd_ready_i,
    input  logic                 clr_ovf_i,
    output logic                 rd_valid_o,
    output logic [2*NUM_PHI-1:0] rd_phi_o,
    output logic [CNT_W-1:0]     rd_count_o,
    output logic [TS_W-1:0]      rd_time_o,
    output logic [FILL_W-1:0]    fill_o,
    output logic                 ovf_o,
    output logic [DROP_W-1:0]    drop_cnt_o
);

    localparam int REC_W = rec_width(NUM_PHI);
    localparam int PHI_W = 2 * NUM_PHI;

    logic [TS_W-1:0]   r_ts;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop;
    logic [REC_W-1:0]  w_wr_rec;
    logic [REC_W-1:0]  w_rd_rec;
    logic              w_full;
    logic              w_drop;

    assign w_wr_rec = {phi_i, count_i, r_ts};
    assign w_drop   = trig_i && w_full;

    anita3_trig_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (clk250_i),
        .i_rst_n   (rst_n_i),
        .i_wr_en   (trig_i),
        .i_wr_data (w_wr_rec),
        .i_rd_en   (rd_ready_i),
        .o_rd_data (w_rd_rec),
        .o_valid   (rd_valid_o),
        .o_full    (w_full),
        .o_fill    (fill_o)
    );

    assign rd_phi_o   = w_rd_rec[REC_W-1 -: PHI_W];
    assign rd_count_o = w_rd_rec[REC_XW-1 -: CNT_W];
    assign rd_time_o  = w_rd_rec[TS_W-1:0];
    assign ovf_o      = r_ovf;
    assign drop_cnt_o = r_drop;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // A drop coinciding with a clear restarts the count at one
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (clr_ovf_i) begin
                r_drop <= DROP_W'(1);
            end else if (r_drop != '1) begin
                r_drop <= r_drop + 1'b1;
            end
        end else if (clr_ovf_i) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

endmodule

// File: tb/tb_anita3_trig_pattern_buffer.sv
// Directed bench for the trigger pattern buffer with hand-computed expectations.
module tb_anita3_trig_pattern_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig;
    logic [31:0] phi;
    logic [7:0]  cnt;
    logic        rdy;
    logic        clr;
    logic        vld;
    logic [31:0] rphi;
    logic [7:0]  rcnt;
    logic [15:0] rtime;
    logic [4:0]  fill;
    logic        ovf;
    logic [7:0]  drop;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always #2 clk = ~clk;

    anita3_trig_pattern_buffer #(
        .NUM_PHI (16),
        .DEPTH   (4)
    ) dut (
        .clk250_i   (clk),
        .rst_n_i    (rst_n),
        .trig_i     (trig),
        .phi_i      (phi),
        .count_i    (cnt),
        .rd_ready_i (rdy),
        .clr_ovf_i  (clr),
        .rd_valid_o (vld),
        .rd_phi_o   (rphi),
        .rd_count_o (rcnt),
        .rd_time_o  (rtime),
        .fill_o     (fill),
        .ovf_o      (ovf),
        .drop_cnt_o (drop)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // cyc tracks the timestamp value held during the current cycle
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        trig  = 1'b0;
        phi   = '0;
        cnt   = '0;
        rdy   = 1'b0;
        clr   = 1'b0;
        repeat (2) step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_phi", rphi, 32'd0);
        chk("rst_cnt", 32'(rcnt), 32'd0);
        chk("rst_time", 32'(rtime), 32'd0);

        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 16) step();
        trig = 1'b1;
        phi  = 32'h0003_0006;
        cnt  = 8'h05;
        step();
        trig = 1'b0;
        chk("one_vld", 32'(vld), 32'd1);
        chk("one_phi", rphi, 32'h0003_0006);
        chk("one_cnt", 32'(rcnt), 32'h05);
        chk("one_time", 32'(rtime), 32'h0010);
        chk("one_fill", 32'(fill), 32'd1);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("one_rd_vld", 32'(vld), 32'd0);
        chk("one_rd_fill", 32'(fill), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            trig = 1'b1;
            phi  = 32'h1111_1111 * i;
            cnt  = 8'(i);
            step();
        end
        trig = 1'b0;
        chk("full_fill", 32'(fill), 32'd4);
        trig = 1'b1;
        phi  = 32'h5555_5555;
        cnt  = 8'd5;
        step();
        trig = 1'b0;
        chk("ovf_fill", 32'(fill), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_drop", 32'(drop), 32'd1);
        chk("ovf_head_cnt", 32'(rcnt), 32'd1);
        chk("ovf_head_phi", rphi, 32'h1111_1111);
        step();
        chk("hold_cnt", 32'(rcnt), 32'd1);

        trig = 1'b1;
        rdy  = 1'b1;
        cnt  = 8'd6;
        step();
        trig = 1'b0;
        rdy  = 1'b0;
        chk("fullrw_fill", 32'(fill), 32'd3);
        chk("fullrw_drop", 32'(drop), 32'd2);
        chk("fullrw_head", 32'(rcnt), 32'd2);

        for (int i = 2; i <= 4; i++) begin
            chk("drain_cnt", 32'(rcnt), 32'(i));
            chk("drain_phi", rphi, 32'h1111_1111 * i);
            rdy = 1'b1;
            step();
            rdy = 1'b0;
        end
        chk("drain_vld", 32'(vld), 32'd0);
        chk("drain_fill", 32'(fill), 32'd0);

        trig = 1'b1;
        rdy  = 1'b1;
        cnt  = 8'h77;
        step();
        trig = 1'b0;
        rdy  = 1'b0;
        chk("emptyrw_vld", 32'(vld), 32'd1);
        chk("emptyrw_fill", 32'(fill), 32'd1);
        chk("emptyrw_cnt", 32'(rcnt), 32'h77);
        rdy = 1'b1;
        step();
        rdy = 1'b0;

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_drop", 32'(drop), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            trig = 1'b1;
            cnt  = 8'(8'h20 + i);
            step();
        end
        repeat (300) step();
        trig = 1'b0;
        chk("sat_drop", 32'(drop), 32'd255);
        chk("sat_ovf", 32'(ovf), 32'd1);
        chk("sat_fill", 32'(fill), 32'd4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat_clr_ovf", 32'(ovf), 32'd0);
        chk("sat_clr_drop", 32'(drop), 32'd0);

        trig = 1'b1;
        clr  = 1'b1;
        step();
        trig = 1'b0;
        clr  = 1'b0;
        chk("clrdrop_ovf", 32'(ovf), 32'd1);
        chk("clrdrop_drop", 32'(drop), 32'd1);

        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("pre_rst_fill", 32'(fill), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(vld), 32'd0);
        chk("arst_fill", 32'(fill), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_cnt", 32'(rcnt), 32'd0);
        step();
        rst_n = 1'b1;
        cyc   = 0;
        trig  = 1'b1;
        cnt   = 8'hA1;
        step();
        trig = 1'b0;
        chk("post_rst_time", 32'(rtime), 32'h0000);
        chk("post_rst_cnt", 32'(rcnt), 32'hA1);
        rdy = 1'b1;
        step();
        rdy = 1'b0;

        while (cyc < 16'hFFFF) step();
        trig = 1'b1;
        cnt  = 8'hB1;
        step();
        cnt = 8'hB2;
        step();
        trig = 1'b0;
        chk("wrap_fill", 32'(fill), 32'd2);
        chk("wrap_t0", 32'(rtime), 32'hFFFF);
        chk("wrap_c0", 32'(rcnt), 32'hB1);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("wrap_t1", 32'(rtime), 32'h0000);
        chk("wrap_c1", 32'(rcnt), 32'hB2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
